adder_stim_checker: RTL

Synthesisable, parametrised stimulus generator and self-checker for adder DUTs. It replaces file-driven vector benches with an on-chip engine. On `start` it issues `NUM_VECTORS` operand pairs from one of three sources: sweep, LFSR, or loaded vector memory. It predicts each sum, compares it against the DUT output after a fixed latency, and reports pass/fail counts. It sits between the bench top (or an on-FPGA test harness) and the adder under test.

---
 rtl/adder_tb_pkg.sv | 26 ++
 rtl/adder_stim_lfsr.sv | 36 +++
 rtl/adder_stim_checker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tb_pkg.sv
// Shared types and constants for the on-chip adder stimulus/checker engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_tb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Operand source encodings; the fourth code falls back to sweep.
   localparam logic [1:0] MODE_SWEEP = 2'd0;
   localparam logic [1:0] MODE_LFSR  = 2'd1;
   localparam logic [1:0] MODE_MEM   = 2'd2;

   // Galois toggle mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
   localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
   localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_0001;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/adder_stim_lfsr.sv
// 32-bit Galois LFSR supplying pseudo-random operand pairs.
// Latency: new state one cycle after load/step.
// Backpressure: none; advances only when step is high, load has priority.
//
// Ports:
//   clk   clock
//   load  reload the (non-zero) seed
//   step  advance one position
//   state current LFSR contents
module adder_stim_lfsr
   import adder_tb_pkg::*;
#(
   parameter logic [31:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        load,
   input  logic        step,
   output logic [31:0] state
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

   logic [31:0] state_q;

   always_ff @(posedge clk) begin
      if (load) begin
         state_q <= SEED_EFF;
      end else if (step) begin
         state_q <= lfsr_next(state_q);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/adder_stim_checker.sv
// Stimulus generator and self-checker for adder DUTs: issues NUM_VECTORS
// operand pairs (sweep / LFSR / vector memory), predicts each sum and compares
// it against dut_sum DUT_LATENCY cycles later; one vector per cycle, no stall.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, mode                      begin a run (IDLE only), operand source
//   load_en/addr/a/b                 vector memory write port (IDLE only)
//   reg_a, reg_b, in_valid           registered operands to the DUT
//   dut_sum                          DUT result
//   busy, done                       run in progress, end-of-run pulse
//   pass_count, err_count            saturating result counters
//   first_err_valid, first_err_idx   first mismatching vector of the run
module adder_stim_checker
   import adder_tb_pkg::*;
#(
   parameter int          DATA_WIDTH  = 8,
   parameter int          NUM_VECTORS = 16,
   parameter int          DUT_LATENCY = 1,
   parameter logic [31:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [1:0]                     mode,
   input  logic                           load_en,
   input  logic [$clog2(NUM_VECTORS)-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0]          load_a,
   input  logic [DATA_WIDTH-1:0]          load_b,
   output logic [DATA_WIDTH-1:0]          reg_a,
   output logic [DATA_WIDTH-1:0]          reg_b,
   output logic                           in_valid,
   input  logic [DATA_WIDTH:0]            dut_sum,
   output logic                           busy,
   output logic                           done,
   output logic [15:0]                    pass_count,
   output logic [15:0]                    err_count,
   output logic                           first_err_valid,
   output logic [$clog2(NUM_VECTORS)-1:0] first_err_idx
);

   localparam int AW = $clog2(NUM_VECTORS);
   localparam int SW = DATA_WIDTH + 1;

   state_t                state_q;
   logic [1:0]            mode_q;
   logic [AW-1:0]         cnt_q;      // index of the vector currently presented
   logic [3:0]            drain_q;
   logic [DATA_WIDTH-1:0] reg_a_q;
   logic [DATA_WIDTH-1:0] reg_b_q;
   logic                  busy_q;
   logic                  done_q;
   logic [15:0]           pass_q;
   logic [15:0]           err_q;
   logic                  fev_q;
   logic [AW-1:0]         fei_q;

   // Stage 0 lines up with the operands on reg_a/reg_b; the last stage lines
   // up with the DUT result, so a zero-latency DUT compares at stage 0.
   logic                  vld_pipe_q [0:DUT_LATENCY];
   logic [SW-1:0]         exp_pipe_q [0:DUT_LATENCY];
   logic [AW-1:0]         idx_pipe_q [0:DUT_LATENCY];

   logic [DATA_WIDTH-1:0] mem_a [0:NUM_VECTORS-1];
   logic [DATA_WIDTH-1:0] mem_b [0:NUM_VECTORS-1];

   logic [1:0]            src_mode;
   logic [AW-1:0]         next_k;
   logic                  issue;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [SW-1:0]         exp_d;
   logic [31:0]           lfsr_state;
   logic                  lfsr_load;
   logic                  cmp_vld;

   // The LFSR is parked on the seed whenever the engine is idle, so the start
   // edge can issue vector 0 straight from it and step for vector 1.
   assign lfsr_load = rst || (state_q == DONE);

   adder_stim_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .load  (lfsr_load),
      .step  (issue),
      .state (lfsr_state)
   );

   // Operands for the vector registered at the coming edge: vector 0 on the
   // start edge (using the live mode input), then cnt_q+1 while running.
   always_comb begin
      src_mode = (state_q == IDLE) ? mode : mode_q;
      next_k   = (state_q == IDLE) ? '0 : cnt_q + AW'(1);
      issue    = ((state_q == IDLE) && start) ||
                 ((state_q == RUN) && (cnt_q != AW'(NUM_VECTORS - 1)));
      op_a     = '0;
      op_b     = '0;
      case (src_mode)
         MODE_LFSR: begin
            op_a = DATA_WIDTH'(lfsr_state);
            op_b = DATA_WIDTH'(lfsr_state >> DATA_WIDTH);
         end
         MODE_MEM: begin
            op_a = mem_a[next_k];
            op_b = mem_b[next_k];
         end
         default: begin
            op_a = DATA_WIDTH'(next_k);
            op_b = ~DATA_WIDTH'(next_k);
         end
      endcase
      exp_d = SW'(op_a) + SW'(op_b);
   end

   assign cmp_vld = vld_pipe_q[DUT_LATENCY];

   always_ff @(posedge clk) begin
      if (load_en && (state_q == IDLE)) begin
         mem_a[load_addr] <= load_a;
         mem_b[load_addr] <= load_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_SWEEP;
         cnt_q   <= '0;
         drain_q <= '0;
         reg_a_q <= '0;
         reg_b_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fei_q   <= '0;
         for (int i = 0; i <= DUT_LATENCY; i++) begin
            vld_pipe_q[i] <= 1'b0;
            exp_pipe_q[i] <= '0;
            idx_pipe_q[i] <= '0;
         end
      end else begin
         vld_pipe_q[0] <= issue;
         exp_pipe_q[0] <= exp_d;
         idx_pipe_q[0] <= next_k;
         for (int i = 1; i <= DUT_LATENCY; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            exp_pipe_q[i] <= exp_pipe_q[i-1];
            idx_pipe_q[i] <= idx_pipe_q[i-1];
         end

         if (issue) begin
            reg_a_q <= op_a;
            reg_b_q <= op_b;
         end

         // Nothing is in flight when a run starts, so clearing wins outright.
         if ((state_q == IDLE) && start) begin
            pass_q <= '0;
            err_q  <= '0;
            fev_q  <= 1'b0;
            fei_q  <= '0;
         end else if (cmp_vld) begin
            if (exp_pipe_q[DUT_LATENCY] == dut_sum) begin
               if (pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
            end else begin
               if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
               if (!fev_q) begin
                  fev_q <= 1'b1;
                  fei_q <= idx_pipe_q[DUT_LATENCY];
               end
            end
         end

         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  mode_q  <= mode;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (cnt_q == AW'(NUM_VECTORS - 1)) begin
                  if (DUT_LATENCY == 0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= DRAIN;
                     drain_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            DRAIN: begin
               if (drain_q == 4'(DUT_LATENCY - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q + 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign reg_a           = reg_a_q;
   assign reg_b           = reg_b_q;
   assign in_valid        = vld_pipe_q[0];
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass_count      = pass_q;
   assign err_count       = err_q;
   assign first_err_valid = fev_q;
   assign first_err_idx   = fei_q;

endmodule
